// File: rtl/sdram_init_checker.sv
// sdram_init_checker
//
// Device-side monitor for the SDRAM command bus. It samples {cs_n,ras_n,cas_n,we_n} and the
// address bus every clock and checks the power-up / init protocol:
//   wait -> precharge-all -> AREF_REQ auto-refreshes -> mode-register set.
// It latches the programmed mode fields, reports init completion, and keeps sticky error flags.
//
// Optional feature macro: SDRAM_CHK_REFRESH_EN
//   Defined   : after init, the refresh interval is monitored (REF_INTERVAL) and err_code[3]
//               flags refresh starvation.
//   Undefined : no refresh timer; err_code[3] is tied to 0.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active-high
//   cmd         in   [3:0]  {cs_n,ras_n,cas_n,we_n}; 1xxx (deselect) is treated as NOP
//   sdram_addr  in   [11:0] address bus; A10 = all-bank on PRE, mode fields on MSET
//   init_done   out  init sequence completed legally
//   mode_bl     out  [2:0] burst length, addr[2:0] at MSET
//   mode_bt     out  burst type, addr[3] at MSET
//   mode_cl     out  [2:0] CAS latency, addr[6:4] at MSET
//   mode_valid  out  latched mode is legal (cl in {2,3}, bl in 0..3, addr[11:7] == 0)
//   aref_cnt    out  [2:0] AREFs seen during init, saturating at 7
//   err_code    out  [3:0] sticky: [0] power-up, [1] sequence, [2] timing, [3] refresh
//   err         out  OR of err_code
module sdram_init_checker #(
  parameter int unsigned PWRUP_CYCLES = 10000,
  parameter int unsigned T_RP         = 1,
  parameter int unsigned T_RFC        = 4,
  parameter int unsigned T_MRD        = 2,
  parameter int unsigned AREF_REQ     = 2
`ifdef SDRAM_CHK_REFRESH_EN
  ,
  parameter int unsigned REF_INTERVAL = 780
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cmd,
  input  logic [11:0] sdram_addr,
  output logic        init_done,
  output logic [2:0]  mode_bl,
  output logic        mode_bt,
  output logic [2:0]  mode_cl,
  output logic        mode_valid,
  output logic [2:0]  aref_cnt,
  output logic [3:0]  err_code,
  output logic        err
);

  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdAref = 4'b0001;
  localparam logic [3:0] CmdMset = 4'b0000;

  localparam int unsigned PwrW = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES + 1) : 1;
  localparam logic [PwrW-1:0] PwrMax = PwrW'(PWRUP_CYCLES);

  typedef enum logic [1:0] {StPwrup, StWaitPre, StWaitAref, StDone} state_e;

  state_e          state_q, state_d;
  logic [PwrW-1:0] pwr_cnt_q, pwr_cnt_d;
  logic [3:0]      gap_q, gap_d;
  logic [3:0]      req_q, req_d;
  logic            seen_q;
  logic [2:0]      aref_cnt_q;
  logic [3:0]      err_code_q, err_code_d;
  logic [2:0]      mode_bl_q, mode_cl_q;
  logic            mode_bt_q, mode_valid_q;

  // Command decode
  logic non_nop, is_pre, is_aref, is_mset, pre_all;
  assign non_nop = ~cmd[3] & (cmd != CmdNop);
  assign is_pre  = (cmd == CmdPre);
  assign is_aref = (cmd == CmdAref);
  assign is_mset = (cmd == CmdMset);
  assign pre_all = is_pre & sdram_addr[10];

  // Per-sample actions decided by the FSM
  logic pwr_err, seq_err, latch_mode, aref_inc;
  logic timing_err, ref_err;
  logic aref_req_met;

  assign aref_req_met = (32'(aref_cnt_q) >= AREF_REQ);

  // Power-up counter, saturating
  always_comb begin
    pwr_cnt_d = pwr_cnt_q;
    if (pwr_cnt_q != PwrMax) pwr_cnt_d = pwr_cnt_q + PwrW'(1);
  end

  // Gap counter and the gap required by the last non-NOP
  always_comb begin
    gap_d = gap_q;
    req_d = req_q;
    if (non_nop) begin
      gap_d = 4'd0;
      case (cmd)
        CmdPre:  req_d = 4'(T_RP);
        CmdAref: req_d = 4'(T_RFC);
        CmdMset: req_d = 4'(T_MRD);
        default: req_d = 4'd0;
      endcase
    end else if (gap_q != 4'hf) begin
      gap_d = gap_q + 4'd1;
    end
  end

  // gap_q counts NOP cycles since the last non-NOP, so this command sits gap_q+1 cycles after it
  assign timing_err = non_nop & seen_q & ((5'(gap_q) + 5'd1) < 5'(req_q));

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StPwrup;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPwrup:    if (pwr_cnt_d == PwrMax) state_d = StWaitPre;
      StWaitPre:  if (pre_all) state_d = StWaitAref;
      StWaitAref: if (is_mset && aref_req_met) state_d = StDone;
      StDone:     state_d = StDone;
    endcase
  end

  // FSM: per-command actions
  always_comb begin
    pwr_err    = 1'b0;
    seq_err    = 1'b0;
    latch_mode = 1'b0;
    aref_inc   = 1'b0;
    unique case (state_q)
      StPwrup: begin
        if (non_nop && (pwr_cnt_q < PwrMax)) pwr_err = 1'b1;
      end
      StWaitPre: begin
        if (non_nop && !pre_all) seq_err = 1'b1;
      end
      StWaitAref: begin
        if (is_aref) begin
          aref_inc = 1'b1;
        end else if (is_mset && aref_req_met) begin
          latch_mode = 1'b1;
        end else if (non_nop && !pre_all) begin
          seq_err = 1'b1;
        end
      end
      StDone: begin
        if (is_mset) latch_mode = 1'b1;
      end
    endcase
  end

`ifdef SDRAM_CHK_REFRESH_EN
  localparam int unsigned RefW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL + 1) : 1;
  localparam logic [RefW-1:0] RefMax = RefW'(REF_INTERVAL);

  logic [RefW-1:0] ref_cnt_q;

  // Counts cycles in DONE since entry or the last AREF; saturates once starvation is flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q <= '0;
    end else if (state_q != StDone || is_aref) begin
      ref_cnt_q <= '0;
    end else if (ref_cnt_q != RefMax) begin
      ref_cnt_q <= ref_cnt_q + RefW'(1);
    end
  end

  assign ref_err = (state_q == StDone) & ~is_aref & ((ref_cnt_q + RefW'(1)) == RefMax);
`else
  assign ref_err = 1'b0;
`endif

  assign err_code_d = err_code_q | {ref_err, timing_err, seq_err, pwr_err};

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_cnt_q    <= '0;
      gap_q        <= 4'd0;
      req_q        <= 4'd0;
      seen_q       <= 1'b0;
      aref_cnt_q   <= 3'd0;
      err_code_q   <= 4'd0;
      mode_bl_q    <= 3'd0;
      mode_bt_q    <= 1'b0;
      mode_cl_q    <= 3'd0;
      mode_valid_q <= 1'b0;
    end else begin
      pwr_cnt_q  <= pwr_cnt_d;
      gap_q      <= gap_d;
      req_q      <= req_d;
      err_code_q <= err_code_d;
      if (non_nop) seen_q <= 1'b1;
      if (aref_inc && aref_cnt_q != 3'd7) aref_cnt_q <= aref_cnt_q + 3'd1;
      if (latch_mode) begin
        mode_bl_q    <= sdram_addr[2:0];
        mode_bt_q    <= sdram_addr[3];
        mode_cl_q    <= sdram_addr[6:4];
        mode_valid_q <= ((sdram_addr[6:4] == 3'd2) || (sdram_addr[6:4] == 3'd3)) &&
                        !sdram_addr[2] && (sdram_addr[11:7] == 5'd0);
      end
    end
  end

  assign init_done  = (state_q == StDone);
  assign mode_bl    = mode_bl_q;
  assign mode_bt    = mode_bt_q;
  assign mode_cl    = mode_cl_q;
  assign mode_valid = mode_valid_q;
  assign aref_cnt   = aref_cnt_q;
  assign err_code   = err_code_q;
  assign err        = |err_code_q;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Directed bench for sdram_init_checker. Inputs change on the falling edge; outputs are
// checked on the falling edge after the rising edge that sampled the command.
// "Edge k" below is the k-th rising edge after reset release.
module tb_sdram_init_checker;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MSET = 4'b0000;
  localparam logic [3:0] ACT  = 4'b0011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cmd = NOP;
  logic [11:0] sdram_addr = 12'h000;
  logic        init_done;
  logic [2:0]  mode_bl;
  logic        mode_bt;
  logic [2:0]  mode_cl;
  logic        mode_valid;
  logic [2:0]  aref_cnt;
  logic [3:0]  err_code;
  logic        err;

  int checks = 0;
  int passes = 0;

  sdram_init_checker dut (
    .clk        (clk),
    .rst        (rst),
    .cmd        (cmd),
    .sdram_addr (sdram_addr),
    .init_done  (init_done),
    .mode_bl    (mode_bl),
    .mode_bt    (mode_bt),
    .mode_cl    (mode_cl),
    .mode_valid (mode_valid),
    .aref_cnt   (aref_cnt),
    .err_code   (err_code),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One command sampled on the next rising edge, then back to NOP
  task automatic drive(input logic [3:0] c, input logic [11:0] a);
    cmd = c;
    sdram_addr = a;
    @(negedge clk);
    cmd = NOP;
    sdram_addr = 12'h000;
  endtask

  task automatic idle(input int n);
    cmd = NOP;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    cmd = NOP;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- Legal sequence ----------------
    do_reset();
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_aref_cnt", 32'(aref_cnt), 0);
    chk("rst_mode", 32'({mode_bl, mode_bt, mode_cl, mode_valid, err}), 0);
    idle(10000);
    drive(PRE, 12'h400);                // edge 10001
    chk("legal_pre_err", 32'(err_code), 0);
    drive(AREF, 12'h000);               // +1
    chk("legal_aref1_cnt", 32'(aref_cnt), 1);
    idle(3);
    drive(AREF, 12'h000);               // +5, exactly T_RFC after
    chk("legal_aref2_cnt", 32'(aref_cnt), 2);
    chk("legal_pre_mset_done", 32'(init_done), 0);
    idle(3);
    drive(MSET, 12'h032);               // +9
    chk("legal_init_done", 32'(init_done), 1);
    chk("legal_bl", 32'(mode_bl), 2);
    chk("legal_bt", 32'(mode_bt), 0);
    chk("legal_cl", 32'(mode_cl), 3);
    chk("legal_mode_valid", 32'(mode_valid), 1);
    chk("legal_aref_cnt", 32'(aref_cnt), 2);
    chk("legal_err", 32'(err), 0);
    // Relatch in DONE: cl=5 is illegal but not a protocol error
    idle(1);
    drive(MSET, 12'h052);
    chk("badmode_cl", 32'(mode_cl), 5);
    chk("badmode_valid", 32'(mode_valid), 0);
    chk("badmode_done_err", 32'({init_done, err}), 32'h2);
    idle(1);
    drive(MSET, 12'h024);               // bl=4
    chk("bl4_fields", 32'({mode_bl, mode_valid}), 32'h8);
    idle(1);
    drive(MSET, 12'h83A);               // bl=2 bt=1 cl=3, addr[11] set
    chk("hibit_fields", 32'({mode_bl, mode_bt, mode_cl, mode_valid}), 32'h56);
    idle(1);
    drive(MSET, 12'h02B);               // bl=3 bt=1 cl=2
    chk("bl3_fields", 32'({mode_bl, mode_bt, mode_cl, mode_valid}), 32'h75);
    idle(1);
    drive(ACT, 12'h000);
    chk("done_act_ok", 32'({init_done, err_code}), 32'h10);

    // ---------------- Early command ----------------
    do_reset();
    chk("reset_clears_done", 32'({init_done, mode_valid, aref_cnt}), 0);
    idle(499);
    drive(PRE, 12'h400);                // edge 500
    chk("early_err_code", 32'(err_code), 1);
    chk("early_done", 32'(init_done), 0);
    idle(9500);
    drive(PRE, 12'h400);                // edge 10001
    drive(AREF, 12'h000);
    idle(3);
    drive(AREF, 12'h000);
    idle(3);
    drive(MSET, 12'h032);
    chk("early_final_err_code", 32'(err_code), 1);
    chk("early_final_done", 32'(init_done), 1);

    // ---------------- Boundary + order violation ----------------
    do_reset();
    idle(9999);
    drive(PRE, 12'h400);                // edge 10000: still too early
    chk("bound_pre_10000", 32'(err_code), 1);
    drive(AREF, 12'h000);               // edge 10001: legal time, wrong order
    chk("order_aref_first", 32'(err_code), 3);
    chk("order_aref_not_counted", 32'(aref_cnt), 0);
    idle(3);
    drive(PRE, 12'h400);
    idle(3);
    drive(AREF, 12'h000);
    chk("order_aref1", 32'(aref_cnt), 1);
    idle(3);
    drive(MSET, 12'h032);               // only one AREF
    chk("order_short_mset_done", 32'(init_done), 0);
    chk("order_short_mset_nolatch", 32'({mode_bl, mode_cl, mode_valid}), 0);
    idle(3);
    drive(AREF, 12'h000);
    idle(3);
    drive(MSET, 12'h032);
    chk("order_final_done", 32'(init_done), 1);
    chk("order_final_err_code", 32'(err_code), 3);
    chk("order_final_bl", 32'(mode_bl), 2);

    // ---------------- Timing violation ----------------
    do_reset();
    idle(10000);
    drive(PRE, 12'h400);
    drive(AREF, 12'h000);
    idle(2);
    drive(AREF, 12'h000);               // 3 cycles after the first
    chk("timing_err_code", 32'(err_code), 4);
    chk("timing_aref_cnt", 32'(aref_cnt), 2);
    idle(3);
    drive(MSET, 12'h032);
    chk("timing_done", 32'(init_done), 1);
    chk("timing_valid", 32'(mode_valid), 1);
    idle(3);
    drive(AREF, 12'h000);               // in DONE: not counted
    chk("done_aref_cnt_holds", 32'(aref_cnt), 2);
    chk("done_aref_err_code", 32'(err_code), 4);
`ifdef SDRAM_CHK_REFRESH_EN
    idle(779);
    chk("refresh_not_yet", 32'(err_code[3]), 0);
    idle(1);
    chk("refresh_starved", 32'(err_code), 32'hC);
`endif

    // ---------------- Reset mid-sequence ----------------
    do_reset();
    idle(10000);
    drive(PRE, 12'h400);
    rst = 1'b1;
    #1;
    chk("async_rst_clear", 32'({init_done, err_code, aref_cnt}), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(19);
    drive(MSET, 12'h032);               // edge 20
    chk("midrst_err_code", 32'(err_code), 1);
    chk("midrst_done", 32'(init_done), 0);
    chk("midrst_nolatch", 32'({mode_bl, mode_cl, mode_valid}), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
